ov7670_capture: RTL and testbench
=================================

# ov7670_capture

Receive-side counterpart to the OV7670 XCLK generator. It samples the camera's returned PCLK, VSYNC, HREF and D[7:0] in the `clk_in` domain and assembles byte pairs into RGB565 pixels with x/y coordinates. It reports frame and line boundaries and flags malformed frames. Its output feeds the edge-detection pipeline's line buffers.

## Interface
Parameters:
- `H_ACTIVE`, 640: pixels per line.
- `V_ACTIVE`, 480: lines per frame.
- `SYNC_STAGES`, 2: synchronizer depth applied to all camera inputs (≥2).

Ports:
- `clk_in` input 1: system clock. Must be ≥4× PCLK frequency.
- `reset` input 1: asynchronous, active-high.
- `cam_pclk` input 1: camera pixel clock, treated as data.
- `cam_vsync` input 1: high during vertical blanking.
- `cam_href` input 1: high during active line bytes.
- `cam_d` input 8: camera data byte.
- `pix_valid` output 1: one-cycle strobe; `pix_data`, `pix_x` and `pix_y` are valid.
- `pix_data` output 16: RGB565, first byte in [15:8].
- `pix_x` output $clog2(H_ACTIVE): column of the emitted pixel.
- `pix_y` output $clog2(V_ACTIVE): row of the emitted pixel.
- `frame_start` output 1: one-cycle pulse on VSYNC falling (frame begins).
- `line_end` output 1: one-cycle pulse on HREF falling inside a frame.
- `frame_done` output 1: one-cycle pulse on VSYNC rising after an active frame.
- `frame_err` output 1: sticky error flag, cleared at `frame_start`.

## Operation
- All four camera inputs pass through an identical `SYNC_STAGES` flop chain, so they remain mutually aligned.
- One extra register on the synchronized pclk, vsync and href provides edge detection.
- PCLK rising edge: `pclk_s && !pclk_d`.
- On each PCLK rising edge, the byte is taken from the synchronized `cam_d` at the same stage as `pclk_s`.
- FSM states:
  - SEEK (reset state): discard everything. Go to VBLANK when synchronized vsync=1. Partial frames after reset are never emitted.
  - VBLANK: on vsync falling → ACTIVE. Pulse `frame_start`; clear `pix_x`, `pix_y`, byte phase and `frame_err`.
  - ACTIVE: on PCLK rise with href=1:
    - Phase 0: latch high byte; phase←1.
    - Phase 1: emit `{hi, d}` with `pix_valid`; phase←0; x counter++.
  - ACTIVE: on href falling:
    - Pulse `line_end`.
    - If phase=1 (odd byte count) or x≠H_ACTIVE, set `frame_err`.
    - x←0, phase←0, y++.
  - ACTIVE: on vsync rising → VBLANK. Pulse `frame_done`. If y≠V_ACTIVE, set `frame_err`.
- Overflow:
  - Pixels with x≥H_ACTIVE are dropped (no `pix_valid`) and set `frame_err`.
  - Lines with y≥V_ACTIVE are dropped and set `frame_err`.
  - Counters saturate and do not wrap.
- Simultaneous vsync rise and href fall in the same cycle: process `line_end` first (counted), then `frame_done`. Both pulses are asserted in the same cycle.
- PCLK edges while href=0 are ignored.

## Timing
- Reset values: FSM=SEEK; all outputs 0; counters and phase 0.
- Latency, PCLK rising at pin to `pix_valid`: SYNC_STAGES+2 `clk_in` cycles (SYNC_STAGES sync, 1 edge register, 1 output register).
- `frame_start`, `line_end` and `frame_done` share the same latency relative to their input edges.
- `pix_data`, `pix_x` and `pix_y` hold their values until the next `pix_valid`.
- `pix_x` and `pix_y` refer to the pixel being emitted, i.e. the pre-increment value.
- Minimum spacing of `pix_valid` is 8 `clk_in` cycles: 2 PCLK periods at 4 cycles each.
- Reset asserted mid-frame: immediate return to SEEK; the next full frame is required before any output.

## Structure
- Package `ov7670_pkg` contains:
  - `cap_state_t` enum {SEEK, VBLANK, ACTIVE}.
  - `rgb565_t` packed struct {r[4:0], g[5:0], b[4:0]}.
  - Constants `OV_H_ACTIVE`=640 and `OV_V_ACTIVE`=480.
- Sub-module `ov7670_in_sync`: parameterized-width N-stage synchronizer bank plus edge-detect register. Outputs synchronized levels and rise/fall strobes for pclk, href and vsync.
- Top level: FSM, byte pairing, counters, error logic.

## Test plan
- Reset mid-VSYNC-low (mid-frame): drive the remainder of the frame → no `pix_valid`. The next frame starts with `frame_start` and first pixel x=0, y=0.
- Bytes 0xF8,0x1F then 0x07,0xE0 on one line (H_ACTIVE=2, V_ACTIVE=1, clk_in=4×PCLK) → `pix_data`=0xF81F at x=0, then 0x07E0 at x=1. Each `pix_valid` arrives SYNC_STAGES+2 cycles after its PCLK rise. `line_end` then `frame_done`; `frame_err`=0.
- Full 4×3 frame with incrementing bytes → exactly 12 `pix_valid`, 3 `line_end`, 1 `frame_done`; pixel i=y·4+x has data {2i, 2i+1}.
- Line with an odd byte count (7 bytes, H_ACTIVE=4) → 3 pixels emitted and `frame_err`=1 after `line_end`. `frame_err` clears at the next `frame_start`.
- Line of 6 pixels with H_ACTIVE=4 → pixels x=4 and x=5 are not emitted and `frame_err`=1.
- Frame with 2 lines when V_ACTIVE=3 → `frame_done` pulses and `frame_err`=1. VSYNC fall coinciding with reset deassertion → stays in SEEK.

Source files
------------

// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 capture path.
package ov7670_pkg;

   localparam int OV_H_ACTIVE = 640;
   localparam int OV_V_ACTIVE = 480;

   typedef enum logic [1:0] {
      SEEK   = 2'd0,
      VBLANK = 2'd1,
      ACTIVE = 2'd2
   } cap_state_t;

   typedef struct packed {
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } rgb565_t;

   // Synchronized camera view: levels and edge strobes, all mutually aligned.
   typedef struct packed {
      logic       pclk_rise;
      logic       href;
      logic       href_fall;
      logic       vsync;
      logic       vsync_rise;
      logic       vsync_fall;
      logic [7:0] d;
   } cam_sync_t;

endpackage

// File: rtl/ov7670_capture_in_sync.sv
// N-stage synchronizer bank for the camera pins plus one edge-detect register.
module ov7670_in_sync
   import ov7670_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic       cam_pclk,
   input  logic       cam_vsync,
   input  logic       cam_href,
   input  logic [7:0] cam_d,
   output cam_sync_t  sync
);

   // bit 10 pclk, 9 vsync, 8 href, 7:0 data
   logic [STAGES-1:0][10:0] chain;
   logic [10:0]             lvl;
   logic                    pclk_d;

   assign lvl = chain[STAGES-1];

   // All pins share one chain so they stay aligned to each other.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) chain <= '0;
      else       chain <= {chain[STAGES-2:0], {cam_pclk, cam_vsync, cam_href, cam_d}};
   end

   // Edge strobes registered together with the data and levels they qualify.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         pclk_d <= 1'b0;
         sync   <= '0;
      end else begin
         pclk_d          <= lvl[10];
         sync.pclk_rise  <= lvl[10] & ~pclk_d;
         sync.href       <= lvl[8];
         sync.href_fall  <= ~lvl[8] & sync.href;
         sync.vsync      <= lvl[9];
         sync.vsync_rise <= lvl[9] & ~sync.vsync;
         sync.vsync_fall <= ~lvl[9] & sync.vsync;
         sync.d          <= lvl[7:0];
      end
   end

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 receive path: byte pairing into RGB565 pixels with x/y, frame/line
// boundary pulses and a sticky malformed-frame flag.
module ov7670_capture
   import ov7670_pkg::*;
#(
   parameter int H_ACTIVE    = OV_H_ACTIVE,
   parameter int V_ACTIVE    = OV_V_ACTIVE,
   parameter int SYNC_STAGES = 2
) (
   input  logic                        clk_in,
   input  logic                        reset,
   input  logic                        cam_pclk,
   input  logic                        cam_vsync,
   input  logic                        cam_href,
   input  logic [7:0]                  cam_d,
   output logic                        pix_valid,
   output logic [15:0]                 pix_data,
   output logic [$clog2(H_ACTIVE)-1:0] pix_x,
   output logic [$clog2(V_ACTIVE)-1:0] pix_y,
   output logic                        frame_start,
   output logic                        line_end,
   output logic                        frame_done,
   output logic                        frame_err
);

   localparam int PXW = $clog2(H_ACTIVE);
   localparam int PYW = $clog2(V_ACTIVE);
   // Internal counters are one value wider so they can saturate at the limit.
   localparam int CXW = $clog2(H_ACTIVE + 1);
   localparam int CYW = $clog2(V_ACTIVE + 1);
   localparam logic [CXW-1:0] H_MAX = CXW'(H_ACTIVE);
   localparam logic [CYW-1:0] V_MAX = CYW'(V_ACTIVE);

   cam_sync_t      cs;
   cap_state_t     state;
   logic [CXW-1:0] x_cnt;
   logic [CYW-1:0] y_cnt;
   logic [CYW-1:0] y_next;
   logic           phase;
   logic [7:0]     hi_byte;
   rgb565_t        pix_r;

   ov7670_in_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk_in    (clk_in),
      .reset     (reset),
      .cam_pclk  (cam_pclk),
      .cam_vsync (cam_vsync),
      .cam_href  (cam_href),
      .cam_d     (cam_d),
      .sync      (cs)
   );

   assign pix_data = pix_r;

   // Row count after a possible line end this cycle, so a coincident frame end sees it.
   always_comb begin
      y_next = y_cnt;
      if (cs.href_fall && (y_cnt < V_MAX)) y_next = y_cnt + CYW'(1);
   end

   // Capture FSM with byte pairing, saturating counters and error tracking.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state       <= SEEK;
         pix_valid   <= 1'b0;
         pix_r       <= '0;
         pix_x       <= '0;
         pix_y       <= '0;
         frame_start <= 1'b0;
         line_end    <= 1'b0;
         frame_done  <= 1'b0;
         frame_err   <= 1'b0;
         x_cnt       <= '0;
         y_cnt       <= '0;
         phase       <= 1'b0;
         hi_byte     <= '0;
      end else begin
         pix_valid   <= 1'b0;
         frame_start <= 1'b0;
         line_end    <= 1'b0;
         frame_done  <= 1'b0;
         case (state)
            SEEK: if (cs.vsync) state <= VBLANK;
            VBLANK: if (cs.vsync_fall) begin
               state       <= ACTIVE;
               frame_start <= 1'b1;
               frame_err   <= 1'b0;
               x_cnt       <= '0;
               y_cnt       <= '0;
               phase       <= 1'b0;
               pix_x       <= '0;
               pix_y       <= '0;
            end
            ACTIVE: begin
               // href_fall implies href is low, so this never overlaps the line end.
               if (cs.pclk_rise && cs.href) begin
                  if (!phase) begin
                     hi_byte <= cs.d;
                     phase   <= 1'b1;
                  end else begin
                     phase <= 1'b0;
                     if ((x_cnt < H_MAX) && (y_cnt < V_MAX)) begin
                        pix_valid <= 1'b1;
                        pix_r     <= rgb565_t'({hi_byte, cs.d});
                        pix_x     <= x_cnt[PXW-1:0];
                        pix_y     <= y_cnt[PYW-1:0];
                     end else begin
                        frame_err <= 1'b1;
                     end
                     if (x_cnt < H_MAX) x_cnt <= x_cnt + CXW'(1);
                  end
               end
               if (cs.href_fall) begin
                  line_end <= 1'b1;
                  if (phase || (x_cnt != H_MAX)) frame_err <= 1'b1;
                  x_cnt <= '0;
                  phase <= 1'b0;
                  y_cnt <= y_next;
               end
               if (cs.vsync_rise) begin
                  state      <= VBLANK;
                  frame_done <= 1'b1;
                  if (y_next != V_MAX) frame_err <= 1'b1;
               end
            end
            default: state <= SEEK;
         endcase
      end
   end

endmodule

// File: tb/tb_ov7670_capture.sv
// Scoreboard bench for ov7670_capture at H_ACTIVE=4, V_ACTIVE=3, clk_in = 4x PCLK.
module tb_ov7670_capture;

   localparam int H    = 4;
   localparam int V    = 3;
   localparam int SYNC = 2;

   logic        clk_in = 1'b0;
   logic        reset  = 1'b1;
   logic        cam_pclk = 1'b0, cam_vsync = 1'b0, cam_href = 1'b0;
   logic [7:0]  cam_d = '0;
   logic        pix_valid, frame_start, line_end, frame_done, frame_err;
   logic [15:0] pix_data;
   logic [1:0]  pix_x;
   logic [1:0]  pix_y;

   ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SYNC_STAGES(SYNC)) dut (
      .clk_in      (clk_in),
      .reset       (reset),
      .cam_pclk    (cam_pclk),
      .cam_vsync   (cam_vsync),
      .cam_href    (cam_href),
      .cam_d       (cam_d),
      .pix_valid   (pix_valid),
      .pix_data    (pix_data),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .frame_start (frame_start),
      .line_end    (line_end),
      .frame_done  (frame_done),
      .frame_err   (frame_err)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [15:0] d;
      int          x;
      int          y;
      longint      cyc;
   } exp_t;

   exp_t   q[$];
   longint cyc = 0;
   int     checks = 0, errors = 0;
   int     fs_cnt = 0, le_cnt = 0, fd_cnt = 0, pix_cnt = 0;

   always @(posedge clk_in) cyc <= cyc + 1;

   // Monitor: counts pulses and checks every emitted pixel against the queue.
   always @(negedge clk_in) begin
      if (!reset) begin
         if (frame_start) fs_cnt++;
         if (line_end)    le_cnt++;
         if (frame_done)  fd_cnt++;
         if (pix_valid) begin
            exp_t e;
            pix_cnt++;
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL pix_unexpected got d=%h x=%0d y=%0d at cyc %0d, required none",
                        pix_data, pix_x, pix_y, cyc);
            end else begin
               e = q.pop_front();
               if (pix_data !== e.d || int'(pix_x) != e.x || int'(pix_y) != e.y || cyc != e.cyc) begin
                  errors++;
                  $display("FAIL pix got d=%h x=%0d y=%0d cyc=%0d, required d=%h x=%0d y=%0d cyc=%0d",
                           pix_data, pix_x, pix_y, cyc, e.d, e.x, e.y, e.cyc);
               end
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic chk(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d required %0d", name, got, exp);
      end
   endtask

   // One PCLK period (2 low, 2 high); optionally expect a pixel from this rise.
   task automatic send_byte(input logic [7:0] b, input bit en, input logic [15:0] ed,
                            input int ex, input int ey);
      exp_t e;
      cam_d    = b;
      cam_pclk = 1'b0;
      tick(2);
      cam_pclk = 1'b1;
      if (en) begin
         e.d = ed; e.x = ex; e.y = ey; e.cyc = cyc + SYNC + 2;
         q.push_back(e);
      end
      tick(2);
   endtask

   // Incrementing bytes from 'first'; only in-range pixels are expected.
   task automatic send_bytes(input int nbytes, input int first, input int y, input bit live);
      for (int k = 0; k < nbytes; k++) begin
         logic [7:0] b, p;
         b = 8'(first + k);
         p = 8'(first + k - 1);
         send_byte(b, live && (k % 2 == 1) && (k / 2 < H) && (y < V), {p, b}, k / 2, y);
      end
      cam_pclk = 1'b0;
   endtask

   task automatic line(input int nbytes, input int first, input int y, input bit live);
      cam_href = 1'b1;
      tick(2);
      send_bytes(nbytes, first, y, live);
      cam_href = 1'b0;
      tick(6);
   endtask

   task automatic frame_begin();
      cam_vsync = 1'b1;
      tick(8);
      cam_vsync = 1'b0;
      tick(8);
   endtask

   task automatic frame_end();
      cam_vsync = 1'b1;
      tick(8);
   endtask

   int fs0, le0, fd0, px0;

   task automatic snap();
      fs0 = fs_cnt; le0 = le_cnt; fd0 = fd_cnt; px0 = pix_cnt;
   endtask

   initial begin
      // Reset state
      tick(3);
      chk("reset_outputs", {pix_valid, pix_data, pix_x, pix_y, frame_start, line_end,
                            frame_done, frame_err}, 0);
      reset = 1'b0;
      tick(2);

      // Partial frame interrupted by reset; vsync falls as reset releases
      frame_begin();
      cam_href = 1'b1;
      tick(2);
      send_byte(8'hAA, 0, 0, 0, 0);
      send_byte(8'h55, 1, 16'hAA55, 0, 0);
      tick(6);
      reset     = 1'b1;
      cam_vsync = 1'b1;
      tick(3);
      reset     = 1'b0;
      cam_vsync = 1'b0;
      cam_href  = 1'b0;
      snap();
      for (int y = 0; y < V; y++) line(8, 8 * y, y, 0);
      frame_end();
      chk("seek_no_pix", pix_cnt - px0, 0);
      chk("seek_no_pulses", fs_cnt - fs0 + le_cnt - le0 + fd_cnt - fd0, 0);

      // Full 4x3 incrementing frame, last href fall coincides with vsync rise
      snap();
      frame_begin();
      chk("A_frame_start", fs_cnt - fs0, 1);
      line(8, 0, 0, 1);
      line(8, 8, 1, 1);
      cam_href = 1'b1;
      tick(2);
      send_bytes(8, 16, 2, 1);
      cam_href  = 1'b0;
      cam_vsync = 1'b1;
      tick(8);
      chk("A_pix_count", pix_cnt - px0, 12);
      chk("A_line_end", le_cnt - le0, 3);
      chk("A_frame_done", fd_cnt - fd0, 1);
      chk("A_err", frame_err, 0);

      // Colour pixels F81F / 07E0 on the first line
      snap();
      frame_begin();
      cam_href = 1'b1;
      tick(2);
      send_byte(8'hF8, 0, 0, 0, 0);
      send_byte(8'h1F, 1, 16'hF81F, 0, 0);
      send_byte(8'h07, 0, 0, 0, 0);
      send_byte(8'hE0, 1, 16'h07E0, 1, 0);
      send_byte(8'h11, 0, 0, 0, 0);
      send_byte(8'h22, 1, 16'h1122, 2, 0);
      send_byte(8'h33, 0, 0, 0, 0);
      send_byte(8'h44, 1, 16'h3344, 3, 0);
      cam_pclk = 1'b0;
      cam_href = 1'b0;
      tick(6);
      chk("B_line_end", le_cnt - le0, 1);
      line(8, 8, 1, 1);
      line(8, 16, 2, 1);
      frame_end();
      chk("B_frame_done", fd_cnt - fd0, 1);
      chk("B_err", frame_err, 0);

      // Odd byte count on a line
      snap();
      frame_begin();
      line(7, 0, 0, 1);
      chk("C_pix_count", pix_cnt - px0, 3);
      chk("C_err_after_line", frame_err, 1);
      line(8, 8, 1, 1);
      line(8, 16, 2, 1);
      frame_end();
      chk("C_err_sticky", frame_err, 1);

      // Over-wide line: x=4,5 dropped
      snap();
      frame_begin();
      chk("D_err_cleared", frame_err, 0);
      line(12, 0, 0, 1);
      chk("D_pix_count", pix_cnt - px0, 4);
      chk("D_err", frame_err, 1);
      line(8, 8, 1, 1);
      line(8, 16, 2, 1);
      frame_end();

      // Short frame: 2 lines of 3
      snap();
      frame_begin();
      line(8, 0, 0, 1);
      line(8, 8, 1, 1);
      chk("E_err_before_end", frame_err, 0);
      frame_end();
      chk("E_frame_done", fd_cnt - fd0, 1);
      chk("E_err", frame_err, 1);

      // Tall frame: 4th line dropped
      snap();
      frame_begin();
      for (int y = 0; y < V; y++) line(8, 8 * y, y, 1);
      chk("F_err_before_extra", frame_err, 0);
      line(8, 24, 3, 1);
      chk("F_err_extra_line", frame_err, 1);
      frame_end();
      chk("F_pix_count", pix_cnt - px0, 12);
      chk("F_line_end", le_cnt - le0, 4);

      tick(10);
      chk("queue_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
